// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, EX/MEM and MEM/WB forwarding taps, EX-side outputs.
// IDEX_FWD_CNT_EN adds the forwarding-event counters to the bus.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [15:0]      id_imm16;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic [RA_W-1:0]  id_waddr;
    logic [2:0]       id_aluctrl;
    logic             id_alusrc;
    logic             id_extop;
    logic             id_regwrite;
    logic             id_memtoreg;
    logic             id_memwrite;

    logic             mem_regwrite;
    logic [RA_W-1:0]  mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             wb_regwrite;
    logic [RA_W-1:0]  wb_waddr;
    logic [WIDTH-1:0] wb_wdata;

    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [2:0]       ex_aluctrl;
    logic [WIDTH-1:0] ex_store_data;
    logic [RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]  ex_rt;
    logic [RA_W-1:0]  ex_waddr;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic             ex_memwrite;
    logic             ex_valid;

`ifdef IDEX_FWD_CNT_EN
    logic [31:0]      fwd_mem_cnt;
    logic [31:0]      fwd_wb_cnt;

    modport master (
        output en, flush, id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_waddr,
               id_aluctrl, id_alusrc, id_extop, id_regwrite, id_memtoreg, id_memwrite,
               mem_regwrite, mem_waddr, mem_wdata, wb_regwrite, wb_waddr, wb_wdata,
        input  ex_a, ex_b, ex_aluctrl, ex_store_data, ex_rs, ex_rt, ex_waddr,
               ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid, fwd_mem_cnt, fwd_wb_cnt
    );

    modport slave (
        input  en, flush, id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_waddr,
               id_aluctrl, id_alusrc, id_extop, id_regwrite, id_memtoreg, id_memwrite,
               mem_regwrite, mem_waddr, mem_wdata, wb_regwrite, wb_waddr, wb_wdata,
        output ex_a, ex_b, ex_aluctrl, ex_store_data, ex_rs, ex_rt, ex_waddr,
               ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid, fwd_mem_cnt, fwd_wb_cnt
    );
`else
    modport master (
        output en, flush, id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_waddr,
               id_aluctrl, id_alusrc, id_extop, id_regwrite, id_memtoreg, id_memwrite,
               mem_regwrite, mem_waddr, mem_wdata, wb_regwrite, wb_waddr, wb_wdata,
        input  ex_a, ex_b, ex_aluctrl, ex_store_data, ex_rs, ex_rt, ex_waddr,
               ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid
    );

    modport slave (
        input  en, flush, id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_waddr,
               id_aluctrl, id_alusrc, id_extop, id_regwrite, id_memtoreg, id_memwrite,
               mem_regwrite, mem_waddr, mem_wdata, wb_regwrite, wb_waddr, wb_wdata,
        output ex_a, ex_b, ex_aluctrl, ex_store_data, ex_rs, ex_rt, ex_waddr,
               ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid
    );
`endif
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and immediate extension.
// Optional: IDEX_FWD_CNT_EN adds saturating forwarding-event counters.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    id_ex_stage_if.slave   bus
);
    logic [WIDTH-1:0] rs_data_q;
    logic [WIDTH-1:0] rt_data_q;
    logic [15:0]      imm_q;
    logic [RA_W-1:0]  rs_q;
    logic [RA_W-1:0]  rt_q;
    logic [RA_W-1:0]  waddr_q;
    logic [2:0]       aluctrl_q;
    logic             alusrc_q;
    logic             extop_q;
    logic             regwrite_q;
    logic             memtoreg_q;
    logic             memwrite_q;
    logic             valid_q;

    logic             mem_hit_a;
    logic             mem_hit_b;
    logic             wb_hit_a;
    logic             wb_hit_b;
    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;
    logic [WIDTH-1:0] imm_ext;

    // Register $0 never matches, so a bubble (rs = rt = 0) cannot forward.
    always_comb begin
        mem_hit_a = bus.mem_regwrite && (bus.mem_waddr != '0) && (bus.mem_waddr == rs_q);
        mem_hit_b = bus.mem_regwrite && (bus.mem_waddr != '0) && (bus.mem_waddr == rt_q);
        wb_hit_a  = bus.wb_regwrite  && (bus.wb_waddr  != '0) && (bus.wb_waddr  == rs_q);
        wb_hit_b  = bus.wb_regwrite  && (bus.wb_waddr  != '0) && (bus.wb_waddr  == rt_q);
    end

    always_comb begin
        fa = rs_data_q;
        if (mem_hit_a)
            fa = bus.mem_wdata;
        else if (wb_hit_a)
            fa = bus.wb_wdata;

        fb = rt_data_q;
        if (mem_hit_b)
            fb = bus.mem_wdata;
        else if (wb_hit_b)
            fb = bus.wb_wdata;
    end

    always_comb begin
        if (extop_q)
            imm_ext = {{(WIDTH-16){imm_q[15]}}, imm_q};
        else
            imm_ext = {{(WIDTH-16){1'b0}}, imm_q};
    end

    // A stall re-latches the forwarded operands so a value retiring from WB is not lost.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            waddr_q    <= '0;
            aluctrl_q  <= '0;
            alusrc_q   <= 1'b0;
            extop_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (bus.en) begin
            rs_data_q  <= bus.id_rs_data;
            rt_data_q  <= bus.id_rt_data;
            imm_q      <= bus.id_imm16;
            rs_q       <= bus.id_rs;
            rt_q       <= bus.id_rt;
            waddr_q    <= bus.id_waddr;
            aluctrl_q  <= bus.id_aluctrl;
            alusrc_q   <= bus.id_alusrc;
            extop_q    <= bus.id_extop;
            regwrite_q <= bus.id_regwrite;
            memtoreg_q <= bus.id_memtoreg;
            memwrite_q <= bus.id_memwrite;
            valid_q    <= 1'b1;
        end else begin
            rs_data_q  <= fa;
            rt_data_q  <= fb;
        end
    end

    assign bus.ex_a          = fa;
    assign bus.ex_store_data = fb;
    assign bus.ex_b          = alusrc_q ? imm_ext : fb;
    assign bus.ex_aluctrl    = aluctrl_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_waddr      = waddr_q;
    assign bus.ex_regwrite   = regwrite_q;
    assign bus.ex_memtoreg   = memtoreg_q;
    assign bus.ex_memwrite   = memwrite_q;
    assign bus.ex_valid      = valid_q;

`ifdef IDEX_FWD_CNT_EN
    logic [31:0] fwd_mem_cnt_q;
    logic [31:0] fwd_wb_cnt_q;
    logic        cnt_slot;

    // Counts only instructions actually leaving EX (valid and not stalled); flush does not clear.
    assign cnt_slot = valid_q && bus.en;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_mem_cnt_q <= '0;
            fwd_wb_cnt_q  <= '0;
        end else if (cnt_slot) begin
            if ((mem_hit_a || mem_hit_b) && (fwd_mem_cnt_q != 32'hFFFF_FFFF))
                fwd_mem_cnt_q <= fwd_mem_cnt_q + 32'd1;
            if (((wb_hit_a && !mem_hit_a) || (wb_hit_b && !mem_hit_b)) &&
                (fwd_wb_cnt_q != 32'hFFFF_FFFF))
                fwd_wb_cnt_q <= fwd_wb_cnt_q + 32'd1;
        end
    end

    assign bus.fwd_mem_cnt = fwd_mem_cnt_q;
    assign bus.fwd_wb_cnt  = fwd_wb_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, multi-cycle corner sequences, random run vs model.
// Define IDEX_FWD_CNT_EN to also check the forwarding counters.
module tb_id_ex_stage;
    localparam int WIDTH = 32;
    localparam int RA_W  = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

    id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, waddr;
        logic [31:0] rs_data, rt_data;
        logic [15:0] imm;
        logic [2:0]  aluctrl;
        logic        alusrc, extop, regwrite, memtoreg, memwrite;
    } instr_t;

    instr_t m;
    longint unsigned m_mem_cnt = 0;
    longint unsigned m_wb_cnt  = 0;

    // 0 = register file value, 1 = from MEM, 2 = from WB
    function automatic int src_of(input logic [4:0] r);
        if (r == 0) return 0;
        if (bus.mem_regwrite && bus.mem_waddr == r) return 1;
        if (bus.wb_regwrite && bus.wb_waddr == r) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
        case (src_of(r))
            1:       return bus.mem_wdata;
            2:       return bus.wb_wdata;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic sx);
        int v;
        v = sx ? int'($signed(imm)) : int'({16'h0, imm});
        return 32'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] b_exp;
        b_exp = m.alusrc ? extend(m.imm, m.extop) : operand(m.rt, m.rt_data);
        chk("ex_a", bus.ex_a, operand(m.rs, m.rs_data));
        chk("ex_b", bus.ex_b, b_exp);
        chk("ex_store_data", bus.ex_store_data, operand(m.rt, m.rt_data));
        chk("ex_aluctrl", 32'(bus.ex_aluctrl), 32'(m.aluctrl));
        chk("ex_rs", 32'(bus.ex_rs), 32'(m.rs));
        chk("ex_rt", 32'(bus.ex_rt), 32'(m.rt));
        chk("ex_waddr", 32'(bus.ex_waddr), 32'(m.waddr));
        chk("ex_ctrl", {29'h0, bus.ex_regwrite, bus.ex_memtoreg, bus.ex_memwrite},
            {29'h0, m.regwrite, m.memtoreg, m.memwrite});
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
`ifdef IDEX_FWD_CNT_EN
        chk("fwd_mem_cnt", bus.fwd_mem_cnt, 32'(m_mem_cnt));
        chk("fwd_wb_cnt", bus.fwd_wb_cnt, 32'(m_wb_cnt));
`endif
    endtask

    // Advance one clock; the model takes its next state from the inputs held across the edge.
    task automatic tick();
        instr_t n;
        int sa, sb;
        n  = m;
        sa = src_of(m.rs);
        sb = src_of(m.rt);
        if (reset) begin
            m_mem_cnt = 0;
            m_wb_cnt  = 0;
        end else if (m.valid && bus.en) begin
            if ((sa == 1 || sb == 1) && m_mem_cnt < 64'hFFFF_FFFF) m_mem_cnt++;
            if ((sa == 2 || sb == 2) && m_wb_cnt < 64'hFFFF_FFFF) m_wb_cnt++;
        end
        if (reset || bus.flush) begin
            n = '{default: '0};
        end else if (bus.en) begin
            n.valid    = 1'b1;
            n.rs       = bus.id_rs;
            n.rt       = bus.id_rt;
            n.waddr    = bus.id_waddr;
            n.rs_data  = bus.id_rs_data;
            n.rt_data  = bus.id_rt_data;
            n.imm      = bus.id_imm16;
            n.aluctrl  = bus.id_aluctrl;
            n.alusrc   = bus.id_alusrc;
            n.extop    = bus.id_extop;
            n.regwrite = bus.id_regwrite;
            n.memtoreg = bus.id_memtoreg;
            n.memwrite = bus.id_memwrite;
        end else begin
            n.rs_data = operand(m.rs, m.rs_data);
            n.rt_data = operand(m.rt, m.rt_data);
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic randomize_id();
        bus.id_rs_data  = $urandom;
        bus.id_rt_data  = $urandom;
        bus.id_imm16    = 16'($urandom);
        bus.id_rs       = 5'($urandom_range(0, 7));
        bus.id_rt       = 5'($urandom_range(0, 7));
        bus.id_waddr    = 5'($urandom);
        bus.id_aluctrl  = 3'($urandom);
        bus.id_alusrc   = 1'($urandom);
        bus.id_extop    = 1'($urandom);
        bus.id_regwrite = 1'($urandom);
        bus.id_memtoreg = 1'($urandom);
        bus.id_memwrite = 1'($urandom);
    endtask

    task automatic pipe_idle();
        bus.mem_regwrite = 1'b0;
        bus.mem_waddr    = '0;
        bus.mem_wdata    = '0;
        bus.wb_regwrite  = 1'b0;
        bus.wb_waddr     = '0;
        bus.wb_wdata     = '0;
    endtask

    task automatic load_instr(input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] ctl,
                              input logic alusrc, input logic extop);
        bus.id_rs_data  = rsd;
        bus.id_rt_data  = rtd;
        bus.id_imm16    = imm;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_waddr    = rt;
        bus.id_aluctrl  = ctl;
        bus.id_alusrc   = alusrc;
        bus.id_extop    = extop;
        bus.id_regwrite = 1'b1;
        bus.id_memtoreg = 1'b0;
        bus.id_memwrite = 1'b1;
        bus.en          = 1'b1;
        bus.flush       = 1'b0;
        pipe_idle();
        tick();
    endtask

    typedef struct {
        logic [31:0] rs_data, rt_data;
        logic [15:0] imm;
        logic [4:0]  rs, rt;
        logic [2:0]  aluctrl;
        logic        alusrc, extop;
        logic        mem_rw;
        logic [4:0]  mem_wa;
        logic [31:0] mem_wd;
        logic        wb_rw;
        logic [4:0]  wb_wa;
        logic [31:0] wb_wd;
        logic [31:0] exp_a, exp_b, exp_sd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h5, 32'h3, 16'h0000, 5'd1, 5'd2, 3'd1, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h5, 32'h3, 32'h3};
        vecs[1] = '{32'h7, 32'h3, 16'h8001, 5'd1, 5'd2, 3'd0, 1'b1, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h7, 32'hFFFF8001, 32'h3};
        vecs[2] = '{32'h7, 32'h3, 16'h8001, 5'd1, 5'd2, 3'd0, 1'b1, 1'b0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h7, 32'h00008001, 32'h3};
        vecs[3] = '{32'h11, 32'h22, 16'h0, 5'd8, 5'd2, 3'd2, 1'b0, 1'b0,
                    1'b1, 5'd8, 32'hAAAA0000, 1'b1, 5'd8, 32'h5555, 32'hAAAA0000, 32'h22, 32'h22};
        vecs[4] = '{32'h11, 32'h22, 16'h0, 5'd8, 5'd2, 3'd2, 1'b0, 1'b0,
                    1'b1, 5'd0, 32'hAAAA0000, 1'b1, 5'd8, 32'h5555, 32'h5555, 32'h22, 32'h22};
        vecs[5] = '{32'h11, 32'h22, 16'h0, 5'd0, 5'd2, 3'd2, 1'b0, 1'b0,
                    1'b1, 5'd0, 32'hAAAA0000, 1'b1, 5'd0, 32'h5555, 32'h11, 32'h22, 32'h22};
        vecs[6] = '{32'h1, 32'h2, 16'h0, 5'd4, 5'd3, 3'd0, 1'b0, 1'b0,
                    1'b1, 5'd5, 32'h0BAD0BAD, 1'b1, 5'd3, 32'hCAFEF00D, 32'h1, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7] = '{32'h44, 32'h55, 16'h7FFF, 5'd4, 5'd6, 3'd3, 1'b1, 1'b1,
                    1'b1, 5'd6, 32'hDEAD0000, 1'b0, 5'd0, 32'h0, 32'h44, 32'h00007FFF, 32'hDEAD0000};
        vecs[8] = '{32'h99, 32'h66, 16'h0, 5'd3, 5'd3, 3'd7, 1'b0, 1'b0,
                    1'b0, 5'd3, 32'hFFFF, 1'b0, 5'd3, 32'hEEEE, 32'h99, 32'h66, 32'h66};
        vecs[9] = '{32'h0, 32'h0, 16'h0, 5'd10, 5'd11, 3'd1, 1'b0, 1'b0,
                    1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2, 32'h1, 32'h2, 32'h2};
    end

    initial begin
        logic [31:0] saved_mem_cnt, saved_wb_cnt;
        m = '{default: '0};
        reset     = 1'b1;
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        pipe_idle();

        // Reset for two cycles with junk on the ID inputs
        for (int i = 0; i < 2; i++) begin
            randomize_id();
            tick();
        end
        #1;
        check_model();
        chk("reset_valid", 32'(bus.ex_valid), 32'h0);
        chk("reset_a", bus.ex_a, 32'h0);
        reset = 1'b0;

        // Directed vectors: capture, then apply the forwarding taps while stalled
        foreach (vecs[i]) begin
            load_instr(vecs[i].rs_data, vecs[i].rt_data, vecs[i].imm, vecs[i].rs, vecs[i].rt,
                       vecs[i].aluctrl, vecs[i].alusrc, vecs[i].extop);
            bus.en           = 1'b0;
            bus.mem_regwrite = vecs[i].mem_rw;
            bus.mem_waddr    = vecs[i].mem_wa;
            bus.mem_wdata    = vecs[i].mem_wd;
            bus.wb_regwrite  = vecs[i].wb_rw;
            bus.wb_waddr     = vecs[i].wb_wa;
            bus.wb_wdata     = vecs[i].wb_wd;
            #1;
            chk($sformatf("vec%0d_a", i), bus.ex_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), bus.ex_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_sd", i), bus.ex_store_data, vecs[i].exp_sd);
            chk($sformatf("vec%0d_ctl", i), 32'(bus.ex_aluctrl), 32'(vecs[i].aluctrl));
            chk($sformatf("vec%0d_valid", i), 32'(bus.ex_valid), 32'h1);
            check_model();
            pipe_idle();
            bus.en = 1'b1;
        end

        // Stall refresh: a WB value seen during a stall must survive after WB goes idle
        load_instr(32'hA, 32'h1, 16'h0, 5'd2, 5'd9, 3'd0, 1'b0, 1'b0);
        bus.en          = 1'b0;
        bus.wb_regwrite = 1'b1;
        bus.wb_waddr    = 5'd9;
        bus.wb_wdata    = 32'h1234;
        #1;
        chk("stall_fwd_b", bus.ex_b, 32'h1234);
        tick();
        pipe_idle();
        #1;
        chk("stall_hold_b", bus.ex_b, 32'h1234);
        chk("stall_hold_sd", bus.ex_store_data, 32'h1234);
        check_model();

        // Flush while stalled produces a bubble; counters untouched
        load_instr(32'h77, 32'h88, 16'h0, 5'd5, 5'd6, 3'd1, 1'b0, 1'b0);
        bus.mem_regwrite = 1'b1;
        bus.mem_waddr    = 5'd5;
        bus.mem_wdata    = 32'h3;
`ifdef IDEX_FWD_CNT_EN
        saved_mem_cnt = bus.fwd_mem_cnt;
        saved_wb_cnt  = bus.fwd_wb_cnt;
`else
        saved_mem_cnt = 32'h0;
        saved_wb_cnt  = 32'h0;
`endif
        bus.en    = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        pipe_idle();
        #1;
        chk("flush_regwrite", 32'(bus.ex_regwrite), 32'h0);
        chk("flush_memwrite", 32'(bus.ex_memwrite), 32'h0);
        chk("flush_valid", 32'(bus.ex_valid), 32'h0);
        chk("flush_a", bus.ex_a, 32'h0);
`ifdef IDEX_FWD_CNT_EN
        chk("flush_mem_cnt", bus.fwd_mem_cnt, saved_mem_cnt);
        chk("flush_wb_cnt", bus.fwd_wb_cnt, saved_wb_cnt);
`endif
        check_model();

        // Reset during a stall discards the held instruction
        load_instr(32'hF00D, 32'hBEEF, 16'h1, 5'd1, 5'd2, 3'd2, 1'b0, 1'b0);
        bus.en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_stall_a", bus.ex_a, 32'h0);
        check_model();

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            randomize_id();
            bus.en           = ($urandom_range(0, 3) != 0);
            bus.flush        = ($urandom_range(0, 15) == 0);
            reset            = ($urandom_range(0, 199) == 0);
            bus.mem_regwrite = 1'($urandom);
            bus.mem_waddr    = 5'($urandom_range(0, 7));
            bus.mem_wdata    = $urandom;
            bus.wb_regwrite  = 1'($urandom);
            bus.wb_waddr     = 5'($urandom_range(0, 7));
            bus.wb_wdata     = $urandom;
            #1;
            check_model();
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
